// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALU ops, control bundle and decoder
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    reg_dst;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  // Unsupported opcodes and functs fall through to an all-zero bundle (NOP).
  function automatic ctrl_t decode(input logic [31:0] inst);
    ctrl_t c;
    c = '0;
    case (inst[31:26])
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        case (inst[5:0])
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c = '0;
        endcase
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_src    = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OP_J:    c.jump = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32x32 register file, write-through to same-cycle readers
module mips_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : (we_i && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : (we_i && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];

endmodule

// File: rtl/mips_pipeline.sv
// rtl/mips_pipeline.sv - five-stage MIPS32 core with forwarding, load-use stall and flush
module mips_pipeline
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Inst,
  input  logic [31:0] readData_Mem,
  output logic [31:0] adr_inst,
  output logic [31:0] adr_Mem,
  output logic [31:0] writeData_Mem,
  output logic        memWrite,
  output logic        memRead
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d, ifid_pc4_q, ifid_pc4_d;
  ctrl_t       idex_ctrl_q, idex_ctrl_d;
  logic [31:0] idex_a_q, idex_b_q, idex_imm_q, idex_pc4_q;
  logic [4:0]  idex_rs_q, idex_rt_q, idex_rd_q;
  logic        exmem_reg_write_q, exmem_mem_to_reg_q, exmem_mem_read_q, exmem_mem_write_q;
  logic [31:0] exmem_alu_q, exmem_wdata_q;
  logic [4:0]  exmem_wa_q;
  logic        memwb_reg_write_q, memwb_mem_to_reg_q;
  logic [31:0] memwb_alu_q, memwb_rdata_q;
  logic [4:0]  memwb_wa_q;

  logic [4:0]  id_rs, id_rt, id_rd, ex_wa;
  logic [31:0] id_a, id_b, id_imm, wb_data;
  logic [31:0] fwd_a, fwd_b, alu_b, alu_y, br_target;
  ctrl_t       id_ctrl;
  logic        ex_taken, load_use, unused_jump;

  assign id_rs   = ifid_inst_q[25:21];
  assign id_rt   = ifid_inst_q[20:16];
  assign id_rd   = ifid_inst_q[15:11];
  assign id_imm  = {{16{ifid_inst_q[15]}}, ifid_inst_q[15:0]};
  assign id_ctrl = decode(ifid_inst_q);
  assign wb_data = memwb_mem_to_reg_q ? memwb_rdata_q : memwb_alu_q;

  mips_regfile u_regfile (
    .clk_i(clk), .rst_i(rst),
    .ra1_i(id_rs), .ra2_i(id_rt),
    .we_i(memwb_reg_write_q), .wa_i(memwb_wa_q), .wd_i(wb_data),
    .rd1_o(id_a), .rd2_o(id_b)
  );

  // The younger producer (EX/MEM) wins over MEM/WB; $0 is never forwarded.
  always_comb begin
    fwd_a = idex_a_q;
    if (exmem_reg_write_q && exmem_wa_q != 5'd0 && exmem_wa_q == idex_rs_q) fwd_a = exmem_alu_q;
    else if (memwb_reg_write_q && memwb_wa_q != 5'd0 && memwb_wa_q == idex_rs_q) fwd_a = wb_data;
    fwd_b = idex_b_q;
    if (exmem_reg_write_q && exmem_wa_q != 5'd0 && exmem_wa_q == idex_rt_q) fwd_b = exmem_alu_q;
    else if (memwb_reg_write_q && memwb_wa_q != 5'd0 && memwb_wa_q == idex_rt_q) fwd_b = wb_data;
    alu_b = idex_ctrl_q.alu_src ? idex_imm_q : fwd_b;
    case (idex_ctrl_q.alu_op)
      ALU_SUB: alu_y = fwd_a - alu_b;
      ALU_AND: alu_y = fwd_a & alu_b;
      ALU_OR:  alu_y = fwd_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      default: alu_y = fwd_a + alu_b;
    endcase
  end

  assign ex_wa       = idex_ctrl_q.reg_dst ? idex_rd_q : idex_rt_q;
  assign ex_taken    = idex_ctrl_q.branch && (fwd_a == fwd_b);
  assign br_target   = idex_pc4_q + {idex_imm_q[29:0], 2'b00};
  assign load_use    = idex_ctrl_q.mem_read && idex_rt_q != 5'd0 &&
                       (idex_rt_q == id_rs || idex_rt_q == id_rt);
  assign unused_jump = idex_ctrl_q.jump;

  // Taken branch beats stall beats jump; a stalled jump simply retries next cycle.
  always_comb begin
    pc_d        = pc_q + 32'd4;
    ifid_inst_d = Inst;
    ifid_pc4_d  = pc_q + 32'd4;
    idex_ctrl_d = id_ctrl;
    if (ex_taken) begin
      pc_d        = br_target;
      ifid_inst_d = '0;
      idex_ctrl_d = '0;
    end else if (load_use) begin
      pc_d        = pc_q;
      ifid_inst_d = ifid_inst_q;
      ifid_pc4_d  = ifid_pc4_q;
      idex_ctrl_d = '0;
    end else if (id_ctrl.jump) begin
      pc_d        = {ifid_pc4_q[31:28], ifid_inst_q[25:0], 2'b00};
      ifid_inst_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0; ifid_inst_q <= '0; ifid_pc4_q <= '0;
      idex_ctrl_q <= '0; idex_a_q <= '0; idex_b_q <= '0; idex_imm_q <= '0; idex_pc4_q <= '0;
      idex_rs_q <= '0; idex_rt_q <= '0; idex_rd_q <= '0;
      exmem_reg_write_q <= 1'b0; exmem_mem_to_reg_q <= 1'b0;
      exmem_mem_read_q <= 1'b0; exmem_mem_write_q <= 1'b0;
      exmem_alu_q <= '0; exmem_wdata_q <= '0; exmem_wa_q <= '0;
      memwb_reg_write_q <= 1'b0; memwb_mem_to_reg_q <= 1'b0;
      memwb_alu_q <= '0; memwb_rdata_q <= '0; memwb_wa_q <= '0;
    end else begin
      pc_q <= pc_d; ifid_inst_q <= ifid_inst_d; ifid_pc4_q <= ifid_pc4_d;
      idex_ctrl_q <= idex_ctrl_d; idex_a_q <= id_a; idex_b_q <= id_b;
      idex_imm_q <= id_imm; idex_pc4_q <= ifid_pc4_q;
      idex_rs_q <= id_rs; idex_rt_q <= id_rt; idex_rd_q <= id_rd;
      exmem_reg_write_q <= idex_ctrl_q.reg_write; exmem_mem_to_reg_q <= idex_ctrl_q.mem_to_reg;
      exmem_mem_read_q <= idex_ctrl_q.mem_read; exmem_mem_write_q <= idex_ctrl_q.mem_write;
      exmem_alu_q <= alu_y; exmem_wdata_q <= fwd_b; exmem_wa_q <= ex_wa;
      memwb_reg_write_q <= exmem_reg_write_q; memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
      memwb_alu_q <= exmem_alu_q; memwb_rdata_q <= readData_Mem; memwb_wa_q <= exmem_wa_q;
    end
  end

  assign adr_inst      = pc_q;
  assign adr_Mem       = exmem_alu_q;
  assign writeData_Mem = exmem_wdata_q;
  assign memWrite      = exmem_mem_write_q;
  assign memRead       = exmem_mem_read_q;

endmodule

// File: tb/tb_mips_pipeline.sv
// tb/tb_mips_pipeline.sv - directed program with fetch/store/load scoreboards
module tb_mips_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Inst, readData_Mem, adr_inst, adr_Mem, writeData_Mem;
  logic        memWrite, memRead;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic [31:0] exp_pc [$];
  logic [63:0] exp_st [$];
  logic [31:0] exp_ld [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] pc_trace [28] = '{
    32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h1C, 32'h20, 32'h24,
    32'h28, 32'h2C, 32'h30, 32'h34, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54,
    32'h58, 32'h5C, 32'h60, 32'h64, 32'h68, 32'h6C, 32'h68, 32'h6C};
  logic [63:0] st_trace [9] = '{
    {32'd8, 32'd12}, {32'd12, 32'd2}, {32'd16, 32'd24}, {32'd20, 32'd1}, {32'd24, 32'd1},
    {32'd28, 32'd0}, {32'd32, 32'd0}, {32'd36, 32'd0}, {32'd40, 32'd12}};

  mips_pipeline dut (
    .clk(clk), .rst(rst), .Inst(Inst), .readData_Mem(readData_Mem),
    .adr_inst(adr_inst), .adr_Mem(adr_Mem), .writeData_Mem(writeData_Mem),
    .memWrite(memWrite), .memRead(memRead)
  );

  always #5 clk = ~clk;

  assign Inst         = imem[adr_inst[7:2]];
  assign readData_Mem = dmem[adr_Mem[7:2]];
  always @(posedge clk) if (memWrite) dmem[adr_Mem[7:2]] <= writeData_Mem;

  function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [31:0] tgt);
    return {6'h02, tgt[27:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [63:0] s;
    @(negedge clk);
    if (exp_pc.size() > 0) check("fetch_adr", adr_inst, exp_pc.pop_front());
    if (memWrite) begin
      if (exp_st.size() == 0) check("stray_store", {31'd0, memWrite}, 32'd0);
      else begin
        s = exp_st.pop_front();
        check("store_adr", adr_Mem, s[63:32]);
        check("store_data", writeData_Mem, s[31:0]);
      end
    end
    if (memRead) begin
      if (exp_ld.size() == 0) check("stray_load", {31'd0, memRead}, 32'd0);
      else check("load_adr", adr_Mem, exp_ld.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin imem[i] = '0; dmem[i] = '0; end
    imem[0]  = i_ins(6'h08, 5'd1, 5'd0, 16'd5);
    imem[1]  = i_ins(6'h08, 5'd2, 5'd0, 16'd7);
    imem[2]  = r_ins(5'd3, 5'd1, 5'd2, 6'h20);
    imem[3]  = r_ins(5'd4, 5'd2, 5'd1, 6'h22);
    imem[4]  = i_ins(6'h2B, 5'd3, 5'd0, 16'd8);
    imem[5]  = i_ins(6'h23, 5'd5, 5'd0, 16'd8);
    imem[6]  = r_ins(5'd6, 5'd5, 5'd5, 6'h20);
    imem[7]  = r_ins(5'd7, 5'd1, 5'd2, 6'h2A);
    imem[8]  = i_ins(6'h04, 5'd1, 5'd1, 16'd2);
    imem[9]  = i_ins(6'h08, 5'd9, 5'd0, 16'd99);
    imem[10] = i_ins(6'h2B, 5'd1, 5'd0, 16'h30);
    imem[11] = i_ins(6'h04, 5'd2, 5'd1, 16'd5);
    imem[12] = j_ins(32'h40);
    imem[13] = i_ins(6'h08, 5'd10, 5'd0, 16'd77);
    imem[14] = i_ins(6'h2B, 5'd1, 5'd0, 16'h34);
    imem[16] = i_ins(6'h08, 5'd0, 5'd0, 16'd9);
    imem[17] = r_ins(5'd8, 5'd0, 5'd7, 6'h25);
    imem[18] = i_ins(6'h2B, 5'd4, 5'd0, 16'd12);
    imem[19] = i_ins(6'h2B, 5'd6, 5'd0, 16'd16);
    imem[20] = i_ins(6'h2B, 5'd7, 5'd0, 16'd20);
    imem[21] = i_ins(6'h2B, 5'd8, 5'd0, 16'd24);
    imem[22] = i_ins(6'h2B, 5'd0, 5'd0, 16'd28);
    imem[23] = i_ins(6'h2B, 5'd9, 5'd0, 16'd32);
    imem[24] = i_ins(6'h2B, 5'd10, 5'd0, 16'd36);
    imem[25] = i_ins(6'h2B, 5'd5, 5'd0, 16'd40);
    imem[26] = j_ins(32'h68);
    foreach (pc_trace[i]) exp_pc.push_back(pc_trace[i]);
    foreach (st_trace[i]) exp_st.push_back(st_trace[i]);
    exp_ld.push_back(32'd8);

    #2;
    check("rst_adr_inst", adr_inst, 32'd0);
    check("rst_memWrite", {31'd0, memWrite}, 32'd0);
    check("rst_memRead", {31'd0, memRead}, 32'd0);
    check("rst_adr_Mem", adr_Mem, 32'd0);
    check("rst_writeData_Mem", writeData_Mem, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("release_adr_inst", adr_inst, 32'd0);

    for (int c = 0; c < 40; c++) cycle();
    check("fetches_left", exp_pc.size(), 32'd0);
    check("stores_left", exp_st.size(), 32'd0);
    check("loads_left", exp_ld.size(), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20 && !memWrite; c++) @(negedge clk);
    check("sw_reached_mem", {31'd0, memWrite}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_memWrite", {31'd0, memWrite}, 32'd0);
    check("async_adr_inst", adr_inst, 32'd0);
    check("async_adr_Mem", adr_Mem, 32'd0);
    #10;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_pipeline.md
Name:
mips_pipeline

Overview:
- Five-stage in-order MIPS32 integer pipeline: IF, ID, EX, MEM, WB.
- Full forwarding, load-use stall and branch/jump flush.
- Instruction memory and data memory are external; the core drives their addresses and consumes their data.
- Top-level CPU core of the design; a testbench pairs it with an InstMem and a DataMem model.

Parameters:
- None. Data width is fixed at 32 bits; the register file has 32 entries.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- Inst  input  32  instruction word at adr_inst (combinational memory read).
- readData_Mem  input  32  data-memory read data at adr_Mem (combinational).
- adr_inst  output  32  byte address of the instruction being fetched (= PC).
- adr_Mem  output  32  data-memory byte address (EX/MEM ALU result).
- writeData_Mem  output  32  store data (EX/MEM rt value after forwarding).
- memWrite  output  1  store strobe; memory writes on the clk edge while high.
- memRead  output  1  load strobe.

Behaviour:
- Reset:
  - Asynchronous on rst high.
  - PC=0; all pipeline registers cleared to a bubble, i.e. all controls 0, so memWrite=0, memRead=0, adr_Mem=0, writeData_Mem=0.
  - Register file cleared to 0.
  - Reset mid-operation discards all in-flight instructions.
- Supported instructions; anything else decodes as NOP:
  - R-type, opcode 0x00, by funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - lw 0x23, sw 0x2B, addi 0x08, beq 0x04, j 0x02.
  - 0x00000000 is a NOP (writes to $0).
- Arithmetic:
  - 32-bit wraparound; no overflow exceptions.
  - Immediates are sign-extended.
  - Branch target = PC+4 + (sext(imm)<<2).
  - Jump target = {PC+4[31:28], addr26, 2'b00}.
- IF: adr_inst = PC. Default next PC = PC+4.
- ID:
  - Decode and register read.
  - The register file writes on the clk edge in WB; an ID read of the register written in WB the same cycle returns the new value (internal bypass).
  - $0 always reads 0; writes to $0 are ignored.
- EX:
  - ALU operation.
  - Forwarding priority for rs/rt: EX/MEM result (if RegWrite and rd≠0), else MEM/WB write value, else ID/EX operand.
  - The forwarded rt is also the store data carried to MEM.
- MEM: drives adr_Mem, writeData_Mem, memWrite, memRead from EX/MEM.
- WB: writes either the ALU result or the load data (readData_Mem captured into MEM/WB) to rd (R-type) or rt (lw, addi).
- Load-use hazard:
  - Condition: the ID/EX instruction is lw with rt≠0 equal to the ID instruction's rs or rt.
  - Response: hold PC and IF/ID one cycle and insert a bubble into ID/EX. Exactly one stall cycle.
- j: resolved in ID; PC ← target; IF/ID flushed. 1-cycle penalty.
- beq:
  - Resolved in EX using forwarded operands.
  - If taken: PC ← target; IF/ID and ID/EX flushed. 2-cycle penalty.
  - If not taken: no penalty (predict not-taken).
- Simultaneous events:
  - A taken beq in EX overrides both a j in ID and a load-use stall.
  - A j in ID overrides a stall only if no stall condition exists; a stall takes precedence because the jump stays in ID.
- Timing: no combinational path from Inst or readData_Mem to any output.

Decomposition:
- Shared package mips_pkg holds:
  - opcode/funct constants
  - ALU-op enum (ADD, SUB, AND, OR, SLT)
  - control-bundle struct (RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, RegDst, Branch, Jump, ALUOp)
- Natural sub-modules:
  - mips_regfile: 32x32, 2 read ports, 1 write port, with write-through bypass.
  - Control decode, ALU and forwarding/hazard logic stay in the top module.

Test Plan:
- Reset/ALU sequence:
  - Stimulus: rst pulse, then addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sub $4,$2,$1.
  - Required: adr_inst=0 after reset; $3=12, $4=2.
  - Forwarding from EX/MEM and MEM/WB is required to get these values, since no NOPs are inserted.
- Store/load:
  - Stimulus: sw $3,8($0) then lw $5,8($0) then add $6,$5,$5.
  - Required: memWrite=1 with adr_Mem=8 and writeData_Mem=12; memRead=1 with adr_Mem=8.
  - Required: exactly one stall (PC holds one cycle); $6=24.
- beq taken:
  - Stimulus: beq $1,$1,+2 at PC 0x20.
  - Required: next fetched adr_inst=0x2C; the two following instructions (0x24, 0x28) cause no register or memory writes.
- beq not taken and j:
  - Stimulus: beq $1,$2 (5≠7), then j 0x40 at PC 0x30.
  - Required: sequential fetch continues after the beq; after the j, adr_inst=0x40 and the instruction at 0x34 is squashed.
- slt and $0 protection:
  - Stimulus: slt $7,$1,$2, then addi $0,$0,9, then or $8,$0,$7.
  - Required: $7=1, $0 reads 0, $8=1.
- Asynchronous reset mid-run:
  - Stimulus: assert rst between clock edges while a sw is in MEM.
  - Required: memWrite drops to 0 immediately and adr_inst=0.
